mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_pkg.sv | 32 +++
 rtl/mul.sv | 37 +++
 rtl/mul_arbiter.sv | 108 ++++++++++
 tb/tb_mul_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared widths, FSM state type and the round-robin grant search for the
// shared-multiplier arbiter.
package mul_pkg;

  localparam int OPND_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Returns {found, index[2:0]}: first set bit of valid at or above ptr,
  // wrapping at n. Sized for up to 8 requesters.
  function automatic logic [3:0] rr_grant(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input logic [3:0] n);
    logic [3:0] idx;
    logic [3:0] res;
    res = '0;
    for (int off = 0; off < 8; off++) begin
      if (4'(off) < n) begin
        idx = {1'b0, ptr} + 4'(off);
        if (idx >= n) idx = idx - n;
        if (!res[3] && valid[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mul.sv
// Combinational radix-4 Booth multiplier, 32x32 signed -> full 64-bit product.
module mul
  import mul_pkg::*;
(
  input  logic [OPND_W-1:0] multiplicand_i,
  input  logic [OPND_W-1:0] multiplier_i,
  output logic [PROD_W-1:0] product_o
);

  logic [OPND_W:0]   b_ext;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] acc;
  logic [2:0]        trip;

  always_comb begin
    b_ext = {multiplier_i, 1'b0};
    a_ext = {{(PROD_W-OPND_W){multiplicand_i[OPND_W-1]}}, multiplicand_i};
    acc   = '0;
    pp    = '0;
    trip  = '0;
    // Each overlapping bit triplet selects a digit in {-2,-1,0,+1,+2}.
    for (int i = 0; i < OPND_W/2; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    product_o = acc;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among N_REQ requesters,
// one transaction in flight: accept -> CALC for CALC_CYCLES -> RESP handshake.
//
//   state   | meaning
//   IDLE    | searching for a requester, req_ready_o one-hot on the grant
//   CALC    | registered operands on the multiplier, counter running down
//   RESP    | product registered, rsp_valid_o on the granted requester
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int CALC_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [OPND_W*N_REQ-1:0] multiplicand_i,
  input  logic [OPND_W*N_REQ-1:0] multiplier_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  input  logic [N_REQ-1:0]        rsp_ready_i,
  output logic [PROD_W-1:0]       product_o,
  output logic                    busy_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant;
  logic [CW-1:0]     cnt;
  logic [OPND_W-1:0] op_a;
  logic [OPND_W-1:0] op_b;
  logic [PROD_W-1:0] product_q;
  logic [PROD_W-1:0] mul_p;

  logic [3:0]        pick;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic              unused_pick;

  assign pick        = rr_grant(8'(req_valid_i), 3'(ptr), 4'(N_REQ));
  assign pick_vld    = pick[3];
  assign pick_idx    = pick[PW-1:0];
  assign unused_pick = ^pick;

  // Only the captured operands reach the multiplier, so requesters may
  // change their inputs freely once accepted.
  mul u_mul (
    .multiplicand_i (op_a),
    .multiplier_i   (op_b),
    .product_o      (mul_p)
  );

  always_comb begin
    req_ready_o = '0;
    if (state == ST_IDLE && pick_vld) req_ready_o[pick_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state == ST_RESP) rsp_valid_o[grant] = 1'b1;
  end

  assign busy_o    = (state != ST_IDLE);
  assign product_o = product_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      product_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            op_a  <= multiplicand_i[OPND_W*pick_idx +: OPND_W];
            op_b  <= multiplier_i[OPND_W*pick_idx +: OPND_W];
            grant <= pick_idx;
            cnt   <= CW'(CALC_CYCLES - 1);
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cnt == '0) begin
            product_q <= mul_p;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[grant]) begin
            ptr   <= (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter (N_REQ=2, CALC_CYCLES=2): vector table
// plus hand-written arbitration, back-pressure, reset-abort and isolation cases.
module tb_mul_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] multiplicand_i;
  logic [63:0] multiplier_i;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [63:0] product_o;
  logic        busy_o;

  mul_arbiter #(.N_REQ(2), .CALC_CYCLES(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .product_o      (product_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    logic [63:0] prod;
  } sb_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   in_resp = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int k);
    logic [1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Scoreboard: compare index and product on the first cycle of each response.
  always @(negedge clk_i) begin
    sb_t e;
    if (rsp_valid_o != '0) begin
      if (!in_resp) begin
        in_resp = 1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid_o=%b with no transaction outstanding", rsp_valid_o);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_idx", 64'(rsp_valid_o), 64'(onehot(e.idx)));
          chk("product", product_o, e.prod);
        end
      end
    end else begin
      in_resp = 0;
    end
  end

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid_o == '0 && lat < 10) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic handshake(input int k);
    rsp_ready_i = onehot(k);
    @(posedge clk_i); #1;
    rsp_ready_i = '0;
    chk("busy_after_rsp", 64'(busy_o), 64'd0);
  endtask

  task automatic run_one(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int lat;
    req_valid_i = onehot(k);
    multiplicand_i[32*k +: 32] = a;
    multiplier_i[32*k +: 32]   = b;
    #1;
    chk("req_ready", 64'(req_ready_o), 64'(onehot(k)));
    @(posedge clk_i);
    sb_q.push_back('{k, exp});
    #1;
    req_valid_i = '0;
    multiplicand_i[32*k +: 32] = $urandom();
    multiplier_i[32*k +: 32]   = $urandom();
    chk("busy_calc", 64'(busy_o), 64'd1);
    chk("ready_calc", 64'(req_ready_o), 64'd0);
    wait_rsp(lat);
    chk("latency", 64'(lat), 64'd2);
    handshake(k);
  endtask

  initial begin
    int lat;
    int n;
    int t0;
    int rise_t[4];

    vecs[0] = '{32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{32'hFFFF_FFFF,  32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[4] = '{32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[5] = '{32'd0,          32'hDEAD_BEEF, 64'h0};
    vecs[6] = '{32'd12345,      32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7};
    vecs[7] = '{32'hFFFF_FFFB,  32'hFFFF_FFFA, 64'h0000_0000_0000_001E};

    rst_ni = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    multiplicand_i = '0;
    multiplier_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_product", product_o, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) run_one(i % 2, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Both requesters hold valid: grants alternate, one response every 4 cycles.
    multiplicand_i = {32'hFFFF_FFFE, 32'd3};
    multiplier_i   = {32'd9, 32'd4};
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    #1;
    chk("alt_first_ready", 64'(req_ready_o), 64'b01);
    for (int i = 0; i < 4; i++) sb_q.push_back('{i % 2, (i % 2 == 0) ? 64'd12 : 64'hFFFF_FFFF_FFFF_FFEE});
    n = 0;
    t0 = cyc;
    while (n < 4 && cyc - t0 < 40) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o != '0) begin
        rise_t[n] = cyc;
        n++;
      end
    end
    req_valid_i = '0;
    chk("alt_rsp_count", 64'(n), 64'd4);
    if (n == 4) for (int i = 1; i < 4; i++) chk("alt_interval", 64'(rise_t[i] - rise_t[i-1]), 64'd4);
    @(posedge clk_i); #1;
    rsp_ready_i = '0;
    @(posedge clk_i); #1;

    // Back-pressure in RESP while req1 waits.
    multiplicand_i = {32'hFFFF_FFFC, 32'd5};
    multiplier_i   = {32'd25, 32'd6};
    req_valid_i = 2'b01;
    #1;
    chk("bp_ready0", 64'(req_ready_o), 64'b01);
    @(posedge clk_i);
    sb_q.push_back('{0, 64'd30});
    #1;
    req_valid_i = 2'b10;
    wait_rsp(lat);
    chk("bp_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_product", product_o, 64'd30);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
      chk("bp_busy", 64'(busy_o), 64'd1);
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 2'b01;
    @(posedge clk_i); #1;
    rsp_ready_i = '0;
    chk("bp_idle", 64'(busy_o), 64'd0);
    chk("bp_ready1", 64'(req_ready_o), 64'b10);
    @(posedge clk_i);
    sb_q.push_back('{1, 64'hFFFF_FFFF_FFFF_FF9C});
    #1;
    req_valid_i = '0;
    chk("bp_busy1", 64'(busy_o), 64'd1);
    wait_rsp(lat);
    chk("bp_latency1", 64'(lat), 64'd2);
    handshake(1);

    // Operand change after acceptance and a non-granted rsp_ready pulse.
    req_valid_i = 2'b10;
    multiplicand_i[63:32] = 32'd1000;
    multiplier_i[63:32]   = 32'hFFFF_FFF9;
    @(posedge clk_i);
    sb_q.push_back('{1, 64'hFFFF_FFFF_FFFF_E4A8});
    #1;
    req_valid_i = '0;
    multiplicand_i[63:32] = 32'd9;
    multiplier_i[63:32]   = 32'd9;
    rsp_ready_i = 2'b01;
    wait_rsp(lat);
    chk("iso_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      chk("iso_rsp_hold", 64'(rsp_valid_o), 64'b10);
      chk("iso_product", product_o, 64'hFFFF_FFFF_FFFF_E4A8);
    end
    rsp_ready_i = '0;
    handshake(1);

    // Reset during CALC aborts silently.
    req_valid_i = 2'b01;
    multiplicand_i[31:0] = 32'd3;
    multiplier_i[31:0]   = 32'd3;
    @(posedge clk_i); #1;
    req_valid_i = '0;
    chk("abort_busy_calc", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("abort_req_ready", 64'(req_ready_o), 64'd0);
    chk("abort_product", product_o, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      chk("abort_no_rsp", 64'(rsp_valid_o), 64'd0);
    end

    // After reset ptr is 0; a withdrawn request leaves no grant behind.
    req_valid_i = 2'b11;
    #1;
    chk("post_rst_ptr", 64'(req_ready_o), 64'b01);
    req_valid_i = '0;
    #1;
    chk("withdrawn_ready", 64'(req_ready_o), 64'd0);
    run_one(0, 32'h1234_5678, 32'h0001_0000, 64'h0000_1234_5678_0000);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
